mawg_capture: RTL and testbench
===============================

Name: mawg_capture

Overview:
- Segmented waveform recorder; the write-side counterpart of the waveform generator.
- Accepts a sample stream (in_valid/in_data) and writes selected samples into wave RAM through a write port (wave_we/wave_addr/wave_data).
- Placement is driven by an internal control table; each entry is {skip, length, offset}.
- Armed by kick; starts on trigger; walks entries 0..ctrl_length-1 once, then returns to idle with a done pulse.

Parameters:
- CTRL_DEPTH, 4, log2 of control-table entries.
- WAVE_DEPTH, 16, wave RAM address width.
- WAVE_WIDTH, 16, sample width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ctrl_addr  in  CTRL_DEPTH  control-table write address.
- ctrl_data  in  2*WAVE_DEPTH+16  entry {skip[15:0], length[WAVE_DEPTH-1:0], offset[WAVE_DEPTH-1:0]}, offset in LSBs.
- ctrl_we  in  1  control-table write strobe.
- kick  in  1  start request.
- busy  out  1  busy_r | kick.
- force_stop  in  1  abort.
- ctrl_length  in  CTRL_DEPTH  number of entries to process.
- trigger  in  1  capture start condition.
- in_valid  in  1  input sample strobe.
- in_data  in  WAVE_WIDTH  input sample.
- wave_we  out  1  RAM write enable.
- wave_addr  out  WAVE_DEPTH  RAM write address.
- wave_data  out  WAVE_WIDTH  RAM write data.
- done  out  1  one-cycle pulse on normal completion.
- capture_count  out  32  samples written since last accepted kick.

Behaviour:
- Control table:
  - 2^CTRL_DEPTH entries; written on ctrl_we in any state; asynchronous read.
  - An entry is read at the moment it is loaded, so writes to not-yet-loaded entries during a capture take effect.
- Reset values: state=IDLE, busy_r=1, wave_we=0, wave_addr=0, wave_data=0, done=0, capture_count=0, all counters 0.
- busy after reset: busy_r clears on the first IDLE cycle with no accepted kick.
- IDLE:
  - Accept when kick=1 && ctrl_length>0 && force_stop=0.
  - On accept: latch ctrl_length_r; entry index=0; capture_count=0; busy_r=1; go to ARM.
  - Otherwise busy_r=0. kick outside IDLE is ignored.
- ARM:
  - Samples are discarded.
  - When trigger=1, load entry 0: skip_cnt=skip, len_cnt=length, addr=offset.
  - Go to SKIP if skip>0, else to CAPTURE.
  - The sample in the trigger cycle is discarded; the stream starts on the next cycle.
- SKIP: on each in_valid=1, skip_cnt decrements; no write. When a sample is consumed with skip_cnt==1, go to CAPTURE.
- CAPTURE, on each in_valid=1:
  - Write in_data to addr.
  - addr increments and wraps modulo 2^WAVE_DEPTH.
  - len_cnt decrements; capture_count increments (wraps at 2^32).
- Segment end:
  - Occurs on the written sample with len_cnt<=1. Length 0 is treated as 1.
  - If index+1 == ctrl_length_r: go to IDLE, done=1 for one cycle, busy_r stays 1 through that cycle.
  - Otherwise index increments and the next entry loads in the same cycle (zero bubble). The following in_valid sample belongs to the new entry's skip/capture phase.
- Write port timing:
  - wave_we/wave_addr/wave_data are registered, one cycle after the accepted in_valid.
  - wave_we=0 on all other cycles.
  - wave_addr/wave_data hold their last values when wave_we=0.
- force_stop:
  - In ARM/SKIP/CAPTURE: go to IDLE next cycle; the sample in that cycle is not written; no done pulse.
  - A write from the previous cycle's sample still appears.
  - capture_count holds.
- in_valid=0 cycles stall all counters. There is no backpressure; the RAM accepts one write per cycle.
- capture_count holds after completion until the next accepted kick.
- reset mid-operation returns every output and state to its reset value on the next edge.

Optional Feature:
- Macro: MAWG_CAPTURE_TRIG_EDGE_EN.
- Defined:
  - trigger is registered into trigger_d every cycle in all states (reset 0).
  - ARM starts only on a rising edge: trigger=1 && trigger_d=0.
  - A trigger already high when ARM is entered does not start the capture.
- Undefined: level-sensitive. trigger=1 in any ARM cycle starts, including ARM's first cycle.

Test Plan:
- Single entry, skip=2, length=4, offset=0x0100, ctrl_length=1:
  - Stimulus: kick, trigger, then 8 consecutive samples 0xA0..0xA7.
  - Response: writes 0xA2..0xA5 to 0x0100..0x0103 on consecutive cycles; done pulse one cycle after the last write's accepting edge; capture_count=4; busy low afterwards.
- Two entries, {0,3,0x0010} and {1,2,0x0020}, with in_valid toggling every other cycle:
  - Response: 3 writes to 0x10..0x12; one skipped sample; 2 writes to 0x20..0x21; no extra gap at the entry switch; capture_count=5.
- Wrap and length-0:
  - Entry {0,3,0xFFFE}: addresses 0xFFFE, 0xFFFF, 0x0000.
  - Entry with length=0: exactly one write.
- force_stop in CAPTURE after 2 of 5 writes:
  - Response: no further wave_we beyond the in-flight one; no done; state IDLE; capture_count=2.
  - A kick with force_stop=1 is rejected; busy drops to 0 the next cycle.
- Trigger behaviour:
  - Undefined build: trigger held high before kick starts immediately.
  - With MAWG_CAPTURE_TRIG_EDGE_EN: the same stimulus waits until trigger drops and rises again.
  - ctrl_length=0 kick: not accepted, no writes.

Source files
------------

// File: rtl/mawg_capture.sv
// mawg_capture: segmented waveform recorder.
// Writes selected samples from an input stream into wave RAM. An internal
// control table of {skip, length, offset} entries decides where they go.
// kick arms the recorder, trigger starts it, and it walks entries
// 0..ctrl_length-1 once before returning to idle with a done pulse.
// Optional build macro MAWG_CAPTURE_TRIG_EDGE_EN: trigger starts the
// capture only on a rising edge instead of on level.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   ctrl_addr/ctrl_data/ctrl_we        control-table write port
//   kick, force_stop, ctrl_length      start request, abort, entry count
//   trigger, in_valid, in_data         start condition and sample stream
//   busy                               busy_r | kick
//   wave_we/wave_addr/wave_data        registered RAM write port
//   done                               one-cycle normal-completion pulse
//   capture_count                      samples written since last accepted kick
module mawg_capture #(
  parameter int unsigned CTRL_DEPTH = 4,
  parameter int unsigned WAVE_DEPTH = 16,
  parameter int unsigned WAVE_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CTRL_DEPTH-1:0]    ctrl_addr,
  input  logic [2*WAVE_DEPTH+15:0] ctrl_data,
  input  logic                     ctrl_we,
  input  logic                     kick,
  output logic                     busy,
  input  logic                     force_stop,
  input  logic [CTRL_DEPTH-1:0]    ctrl_length,
  input  logic                     trigger,
  input  logic                     in_valid,
  input  logic [WAVE_WIDTH-1:0]    in_data,
  output logic                     wave_we,
  output logic [WAVE_DEPTH-1:0]    wave_addr,
  output logic [WAVE_WIDTH-1:0]    wave_data,
  output logic                     done,
  output logic [31:0]              capture_count
);

  localparam int unsigned ENTRIES = 1 << CTRL_DEPTH;
  localparam int unsigned ENTRY_W = 2 * WAVE_DEPTH + 16;
  localparam int unsigned IDX_W   = CTRL_DEPTH + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_SKIP = 2'd2;
  localparam logic [1:0] ST_CAPT = 2'd3;

  logic [ENTRY_W-1:0]    ctrl_mem_q [ENTRIES];

  logic [1:0]            state_q, state_d;
  logic                  busy_q, busy_d;
  logic [CTRL_DEPTH-1:0] idx_q, idx_d;
  logic [CTRL_DEPTH-1:0] len_reg_q, len_reg_d;
  logic [15:0]           skip_cnt_q, skip_cnt_d;
  logic [WAVE_DEPTH-1:0] len_cnt_q, len_cnt_d;
  logic [WAVE_DEPTH-1:0] addr_q, addr_d;
  logic                  wave_we_q, wave_we_d;
  logic [WAVE_DEPTH-1:0] wave_addr_q, wave_addr_d;
  logic [WAVE_WIDTH-1:0] wave_data_q, wave_data_d;
  logic                  done_q, done_d;
  logic [31:0]           cap_cnt_q, cap_cnt_d;

  logic                  trig_start_c;
  logic                  load_c;
  logic [CTRL_DEPTH-1:0] load_idx_c;
  logic [ENTRY_W-1:0]    entry_c;
  logic [15:0]           ent_skip_c;
  logic [WAVE_DEPTH-1:0] ent_len_c;
  logic [WAVE_DEPTH-1:0] ent_off_c;
  logic                  last_entry_c;

  // Control table: writable in any state, read asynchronously at load time
  always_ff @(posedge clk) begin
    if (ctrl_we) begin
      ctrl_mem_q[ctrl_addr] <= ctrl_data;
    end
  end

`ifdef MAWG_CAPTURE_TRIG_EDGE_EN
  logic trigger_d_q;

  // Previous trigger value, tracked in every state for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      trigger_d_q <= 1'b0;
    end else begin
      trigger_d_q <= trigger;
    end
  end

  assign trig_start_c = trigger & ~trigger_d_q;
`else
  assign trig_start_c = trigger;
`endif

  // ARM always loads entry 0; a segment end loads the next entry
  assign load_idx_c   = (state_q == ST_ARM) ? '0 : idx_q + CTRL_DEPTH'(1);
  assign entry_c      = ctrl_mem_q[load_idx_c];
  assign ent_off_c    = entry_c[WAVE_DEPTH-1:0];
  assign ent_len_c    = entry_c[2*WAVE_DEPTH-1:WAVE_DEPTH];
  assign ent_skip_c   = entry_c[ENTRY_W-1:2*WAVE_DEPTH];
  assign last_entry_c = (IDX_W'(idx_q) + IDX_W'(1)) == IDX_W'(len_reg_q);

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    idx_d       = idx_q;
    len_reg_d   = len_reg_q;
    skip_cnt_d  = skip_cnt_q;
    len_cnt_d   = len_cnt_q;
    addr_d      = addr_q;
    wave_we_d   = 1'b0;
    wave_addr_d = wave_addr_q;
    wave_data_d = wave_data_q;
    done_d      = 1'b0;
    cap_cnt_d   = cap_cnt_q;
    load_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (kick && (ctrl_length != '0) && !force_stop) begin
          len_reg_d = ctrl_length;
          idx_d     = '0;
          cap_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_ARM;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_ARM: begin
        if (force_stop) begin
          state_d = ST_IDLE;
        end else if (trig_start_c) begin
          load_c = 1'b1;
        end
      end
      ST_SKIP: begin
        if (force_stop) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          skip_cnt_d = skip_cnt_q - 16'd1;
          if (skip_cnt_q == 16'd1) begin
            state_d = ST_CAPT;
          end
        end
      end
      ST_CAPT: begin
        if (force_stop) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          wave_we_d   = 1'b1;
          wave_addr_d = addr_q;
          wave_data_d = in_data;
          addr_d      = addr_q + WAVE_DEPTH'(1);
          len_cnt_d   = len_cnt_q - WAVE_DEPTH'(1);
          cap_cnt_d   = cap_cnt_q + 32'd1;
          // Length 0 ends after one write, same as length 1
          if (len_cnt_q <= WAVE_DEPTH'(1)) begin
            if (last_entry_c) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              idx_d  = idx_q + CTRL_DEPTH'(1);
              load_c = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Zero-bubble entry load shared by ARM start and segment switch
    if (load_c) begin
      skip_cnt_d = ent_skip_c;
      len_cnt_d  = ent_len_c;
      addr_d     = ent_off_c;
      state_d    = (ent_skip_c != 16'd0) ? ST_SKIP : ST_CAPT;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b1;
      idx_q       <= '0;
      len_reg_q   <= '0;
      skip_cnt_q  <= '0;
      len_cnt_q   <= '0;
      addr_q      <= '0;
      wave_we_q   <= 1'b0;
      wave_addr_q <= '0;
      wave_data_q <= '0;
      done_q      <= 1'b0;
      cap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      idx_q       <= idx_d;
      len_reg_q   <= len_reg_d;
      skip_cnt_q  <= skip_cnt_d;
      len_cnt_q   <= len_cnt_d;
      addr_q      <= addr_d;
      wave_we_q   <= wave_we_d;
      wave_addr_q <= wave_addr_d;
      wave_data_q <= wave_data_d;
      done_q      <= done_d;
      cap_cnt_q   <= cap_cnt_d;
    end
  end

  assign busy          = busy_q | kick;
  assign wave_we       = wave_we_q;
  assign wave_addr     = wave_addr_q;
  assign wave_data     = wave_data_q;
  assign done          = done_q;
  assign capture_count = cap_cnt_q;

endmodule

// File: tb/tb_mawg_capture.sv
// Self-checking bench for mawg_capture: table of single/two-entry captures
// plus hand sequences for abort, rejected kicks, held trigger and reset.
// Expected writes are queued as samples are driven and popped per write.
module tb_mawg_capture;

`ifdef MAWG_CAPTURE_TRIG_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ctrl_addr;
  logic [47:0] ctrl_data;
  logic        ctrl_we;
  logic        kick;
  logic        busy;
  logic        force_stop;
  logic [3:0]  ctrl_length;
  logic        trigger;
  logic        in_valid;
  logic [15:0] in_data;
  logic        wave_we;
  logic [15:0] wave_addr;
  logic [15:0] wave_data;
  logic        done;
  logic [31:0] capture_count;

  mawg_capture dut (
    .clk(clk), .reset(reset),
    .ctrl_addr(ctrl_addr), .ctrl_data(ctrl_data), .ctrl_we(ctrl_we),
    .kick(kick), .busy(busy), .force_stop(force_stop),
    .ctrl_length(ctrl_length), .trigger(trigger),
    .in_valid(in_valid), .in_data(in_data),
    .wave_we(wave_we), .wave_addr(wave_addr), .wave_data(wave_data),
    .done(done), .capture_count(capture_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  logic [31:0] sb_q[$];
  logic [47:0] shadow [16];

  // Reference model state
  int          m_st = 0;   // 0 idle, 1 armed, 2 running
  bit          m_trig_d = 1'b0;
  int          m_idx, m_n, m_skip, m_left;
  logic [15:0] m_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        n_done++;
        chk("done_with_last_write", 32'(wave_we), 32'd1);
      end
      if (wave_we) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr %h data %h at %0t", wave_addr, wave_data, $time);
        end else begin
          logic [31:0] e;
          e = sb_q.pop_front();
          chk("wr_addr", 32'(wave_addr), 32'(e[31:16]));
          chk("wr_data", 32'(wave_data), 32'(e[15:0]));
        end
      end
    end
  end

  task automatic load_ent(input int i);
    logic [47:0] e;
    e = shadow[i];
    m_skip = int'(e[47:32]);
    m_left = (e[31:16] == 16'd0) ? 1 : int'(e[31:16]);
    m_addr = e[15:0];
  endtask

  // Drive one cycle and advance the model across the same edge
  task automatic cyc(input logic k, input logic v, input logic [15:0] d,
                     input logic t, input logic s);
    kick = k; in_valid = v; in_data = d; trigger = t; force_stop = s;
    case (m_st)
      0: if (k && ctrl_length != 4'd0 && !s) begin
           m_st = 1; m_idx = 0; m_n = int'(ctrl_length);
         end
      1: if (s) m_st = 0;
         else if (t && (!EDGE || !m_trig_d)) begin load_ent(0); m_st = 2; end
      2: if (s) m_st = 0;
         else if (v) begin
           if (m_skip != 0) m_skip--;
           else begin
             sb_q.push_back({m_addr, d});
             m_addr = m_addr + 16'd1;
             m_left--;
             if (m_left == 0) begin
               m_idx++;
               if (m_idx == m_n) m_st = 0;
               else load_ent(m_idx);
             end
           end
         end
      default: m_st = 0;
    endcase
    m_trig_d = t;
    @(posedge clk); #1;
  endtask

  task automatic wr_ctrl(input int i, input logic [15:0] sk, input logic [15:0] ln,
                         input logic [15:0] of);
    ctrl_addr = 4'(i);
    ctrl_data = {sk, ln, of};
    shadow[i] = {sk, ln, of};
    ctrl_we   = 1'b1;
    cyc(0, 0, 16'h0, 0, 0);
    ctrl_we   = 1'b0;
  endtask

  typedef struct {
    logic [15:0] s0, l0, o0, s1, l1, o1;
    int          nent;
    int          nsamp;
    bit          gap;
    logic [31:0] exp_cnt;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vt[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [15:0] base;

    vt[0] = '{16'd2, 16'd4, 16'h0100, 16'd0, 16'd0, 16'h0, 1, 8, 1'b0, 32'd4, 16'h0103};
    vt[1] = '{16'd0, 16'd3, 16'hFFFE, 16'd0, 16'd0, 16'h0, 1, 5, 1'b0, 32'd3, 16'h0000};
    vt[2] = '{16'd0, 16'd0, 16'h0040, 16'd0, 16'd0, 16'h0, 1, 4, 1'b0, 32'd1, 16'h0040};
    vt[3] = '{16'd3, 16'd2, 16'h1234, 16'd0, 16'd0, 16'h0, 1, 7, 1'b1, 32'd2, 16'h1235};
    vt[4] = '{16'd0, 16'd3, 16'h0010, 16'd1, 16'd2, 16'h0020, 2, 8, 1'b1, 32'd5, 16'h0021};
    vt[5] = '{16'd2, 16'd2, 16'h0200, 16'd0, 16'd1, 16'h0300, 2, 7, 1'b0, 32'd3, 16'h0300};

    reset = 1'b1; ctrl_addr = '0; ctrl_data = '0; ctrl_we = 1'b0; kick = 1'b0;
    force_stop = 1'b0; ctrl_length = '0; trigger = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wave_we", 32'(wave_we), 32'd0);
    chk("rst_wave_addr", 32'(wave_addr), 32'd0);
    chk("rst_wave_data", 32'(wave_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_capture_count", capture_count, 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    cyc(0, 0, 16'h0, 0, 0);
    chk("busy_after_reset_idle", 32'(busy), 32'd0);

    // Table-driven captures
    for (int r = 0; r < 6; r++) begin
      wr_ctrl(0, vt[r].s0, vt[r].l0, vt[r].o0);
      if (vt[r].nent > 1) wr_ctrl(1, vt[r].s1, vt[r].l1, vt[r].o1);
      ctrl_length = 4'(vt[r].nent);
      d0 = n_done;
      cyc(1, 0, 16'h0, 0, 0);
      kick = 1'b0;
      #1;
      chk("busy_while_armed", 32'(busy), 32'd1);
      cyc(0, 1, 16'hDEAD, 1, 0);
      base = 16'(16'h00A0 + r * 256);
      for (int i = 0; i < vt[r].nsamp; i++) begin
        cyc(0, 1, base + 16'(i), 0, 0);
        if (vt[r].gap) cyc(0, 0, 16'hBEEF, 0, 0);
      end
      repeat (3) cyc(0, 0, 16'h0, 0, 0);
      chk("row_done_pulses", 32'(n_done - d0), 32'd1);
      chk("row_capture_count", capture_count, vt[r].exp_cnt);
      chk("row_last_addr", 32'(wave_addr), 32'(vt[r].exp_last));
      chk("row_sb_empty", 32'(sb_q.size()), 32'd0);
      chk("row_busy_low", 32'(busy), 32'd0);
    end

    // force_stop after two of five writes
    wr_ctrl(0, 16'd0, 16'd5, 16'h0050);
    ctrl_length = 4'd1;
    d0 = n_done;
    cyc(1, 0, 16'h0, 0, 0);
    cyc(0, 1, 16'hDEAD, 1, 0);
    cyc(0, 1, 16'hC000, 0, 0);
    cyc(0, 1, 16'hC001, 0, 0);
    cyc(0, 1, 16'hC002, 0, 1);
    repeat (3) cyc(0, 1, 16'hC0FF, 0, 0);
    chk("stop_no_done", 32'(n_done - d0), 32'd0);
    chk("stop_capture_count", capture_count, 32'd2);
    chk("stop_last_addr", 32'(wave_addr), 32'h0051);
    chk("stop_last_data", 32'(wave_data), 32'hC001);
    chk("stop_busy_low", 32'(busy), 32'd0);
    chk("stop_sb_empty", 32'(sb_q.size()), 32'd0);

    // Kick with force_stop is rejected
    kick = 1'b1; force_stop = 1'b1; #1;
    chk("reject_busy_passthru", 32'(busy), 32'd1);
    cyc(1, 0, 16'h0, 0, 1);
    cyc(0, 0, 16'h0, 0, 0);
    chk("reject_busy_low", 32'(busy), 32'd0);
    repeat (2) cyc(0, 1, 16'hD000, 1, 0);
    repeat (2) cyc(0, 0, 16'h0, 0, 0);
    chk("reject_count_held", capture_count, 32'd2);

    // Kick with ctrl_length=0 is rejected
    ctrl_length = 4'd0;
    cyc(1, 0, 16'h0, 0, 0);
    repeat (2) cyc(0, 1, 16'hD100, 1, 0);
    repeat (2) cyc(0, 0, 16'h0, 0, 0);
    chk("len0_busy_low", 32'(busy), 32'd0);
    chk("len0_count_held", capture_count, 32'd2);
    chk("len0_sb_empty", 32'(sb_q.size()), 32'd0);

    // Trigger already high when ARM is entered
    wr_ctrl(0, 16'd0, 16'd2, 16'h0070);
    ctrl_length = 4'd1;
    d0 = n_done;
    cyc(0, 0, 16'h0, 1, 0);
    cyc(1, 0, 16'h0, 1, 0);
    cyc(0, 1, 16'h00B0, 1, 0);
    cyc(0, 1, 16'h00B1, 1, 0);
    cyc(0, 1, 16'h00B2, 0, 0);
    cyc(0, 1, 16'h00B3, 1, 0);
    for (int i = 4; i < 8; i++) cyc(0, 1, 16'h00B0 + 16'(i), 0, 0);
    repeat (2) cyc(0, 0, 16'h0, 0, 0);
    chk("trig_done", 32'(n_done - d0), 32'd1);
    chk("trig_count", capture_count, 32'd2);
    chk("trig_last_addr", 32'(wave_addr), 32'h0071);
    chk("trig_last_data", 32'(wave_data), EDGE ? 32'h00B5 : 32'h00B2);

    // Reset in the middle of a capture
    wr_ctrl(0, 16'd0, 16'd8, 16'h0090);
    cyc(1, 0, 16'h0, 0, 0);
    cyc(0, 1, 16'hDEAD, 1, 0);
    cyc(0, 1, 16'h00E0, 0, 0);
    cyc(0, 1, 16'h00E1, 0, 0);
    cyc(0, 0, 16'h0, 0, 0);
    chk("pre_reset_count", capture_count, 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_wave_we", 32'(wave_we), 32'd0);
    chk("midrst_wave_addr", 32'(wave_addr), 32'd0);
    chk("midrst_count", capture_count, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    m_st = 0; m_trig_d = 1'b0;
    sb_q.delete();
    repeat (3) cyc(0, 1, 16'h00E5, 0, 0);
    chk("postrst_busy_low", 32'(busy), 32'd0);
    chk("postrst_count", capture_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
